// File: rtl/lc3b_mem_ctrl.sv
// Multi-cycle byte-addressed little-endian RAM access stage behind the MAR; r pulses LATENCY+1 cycles after accept,
// or 1 cycle after accept for an unaligned word. Requests are only sampled in IDLE, and inputs are ignored while busy.
module lc3b_mem_ctrl #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mio_en,
    input  logic [15:0] mar_addr,
    input  logic        mar_size,
    input  logic        mar_write,
    input  logic [15:0] mdr_in,
    output logic [15:0] mem_data,
    output logic        r,
    output logic        busy,
    output logic        align_err
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic                   size_q, size_d;
    logic                   write_q, write_d;
    logic [15:0]            wdat_q, wdat_d;
    logic [15:0]            mem_data_q, mem_data_d;
    logic                   r_q, r_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;
    logic                   ram_we;
    logic [ADDR_BITS-1:0]   addr_hi;
    logic [15:0]            rd_word;

    logic [7:0] ram [0:(1<<ADDR_BITS)-1];

    // Word accesses are always even here, so a+1 stays inside the RAM.
    assign addr_hi = addr_q + ADDR_BITS'(1);
    assign rd_word = size_q ? {ram[addr_hi], ram[addr_q]} : {8'h00, ram[addr_q]};

    if (ADDR_BITS < 16) begin : g_alias
        logic unused_hi;
        assign unused_hi = ^mar_addr[15:ADDR_BITS];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        size_d     = size_q;
        write_d    = write_q;
        wdat_d     = wdat_q;
        mem_data_d = mem_data_q;
        r_d        = 1'b0;
        busy_d     = busy_q;
        err_d      = 1'b0;
        ram_we     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mio_en) begin
                    addr_d  = mar_addr[ADDR_BITS-1:0];
                    size_d  = mar_size;
                    write_d = mar_write;
                    wdat_d  = mdr_in;
                    busy_d  = 1'b1;
                    if (mar_size && mar_addr[0]) begin
                        state_d    = S_DONE;
                        r_d        = 1'b1;
                        err_d      = 1'b1;
                        mem_data_d = 16'h0000;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = S_DONE;
                    r_d     = 1'b1;
                    if (write_q) ram_we = 1'b1;
                    else         mem_data_d = rd_word;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            addr_q     <= '0;
            size_q     <= 1'b0;
            write_q    <= 1'b0;
            wdat_q     <= 16'h0000;
            mem_data_q <= 16'h0000;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            write_q    <= write_d;
            wdat_q     <= wdat_d;
            mem_data_q <= mem_data_d;
            r_q        <= r_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[addr_q] <= wdat_q[7:0];
            if (size_q) ram[addr_hi] <= wdat_q[15:8];
        end
    end

    assign mem_data  = mem_data_q;
    assign r         = r_q;
    assign busy      = busy_q;
    assign align_err = err_q;
endmodule

// File: tb/tb_lc3b_mem_ctrl.sv
// Directed plus randomized bench for lc3b_mem_ctrl against a byte-array reference model.
module tb_lc3b_mem_ctrl;
    localparam int LAT   = 4;
    localparam int ABITS = 10;
    localparam int DEPTH = 1 << ABITS;

    logic        clk;
    logic        rst_n;
    logic        mio_en;
    logic [15:0] mar_addr;
    logic        mar_size;
    logic        mar_write;
    logic [15:0] mdr_in;
    logic [15:0] mem_data;
    logic        r;
    logic        busy;
    logic        align_err;

    int total  = 0;
    int passed = 0;

    logic [7:0]  mem_m [DEPTH];
    bit          known [DEPTH];
    logic [15:0] md_m;
    logic [15:0] last_rd;

    lc3b_mem_ctrl #(.ADDR_BITS(ABITS), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mio_en    (mio_en),
        .mar_addr  (mar_addr),
        .mar_size  (mar_size),
        .mar_write (mar_write),
        .mdr_in    (mdr_in),
        .mem_data  (mem_data),
        .r         (r),
        .busy      (busy),
        .align_err (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // One complete access through the DUT, checked against the model, which is then updated.
    task automatic run(input logic [15:0] addr, input logic sz, input logic wr, input logic [15:0] dat);
        int          a;
        int          lat;
        int          exp_lat;
        bit          err;
        bit          busy_ok;
        logic [15:0] exp_md;
        a       = addr % DEPTH;
        err     = sz && addr[0];
        exp_lat = err ? 1 : LAT + 1;
        if (err)      exp_md = 16'h0000;
        else if (!wr) exp_md = sz ? {mem_m[a+1], mem_m[a]} : {8'h00, mem_m[a]};
        else          exp_md = md_m;

        @(negedge clk);
        mio_en = 1'b1; mar_addr = addr; mar_size = sz; mar_write = wr; mdr_in = dat;
        @(posedge clk);
        #1;
        mio_en    = 1'b0;
        mar_addr  = 16'($urandom);
        mdr_in    = 16'($urandom);
        mar_size  = 1'($urandom);
        mar_write = 1'($urandom);
        lat     = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (!busy) busy_ok = 1'b0;
        end while (!r && lat < 400);
        check("latency", lat, exp_lat);
        check("busy_during", 32'(busy_ok), 32'd1);
        check("align_err", 32'(align_err), 32'(err));
        check("mem_data", 32'(mem_data), 32'(exp_md));
        last_rd = mem_data;
        @(negedge clk);
        check("r_busy_after", {30'd0, r, busy}, 32'd0);

        if (wr && !err) begin
            mem_m[a] = dat[7:0];
            known[a] = 1'b1;
            if (sz) begin
                mem_m[a+1] = dat[15:8];
                known[a+1] = 1'b1;
            end
        end
        md_m = exp_md;
    endtask

    initial begin : main
        int          npulse;
        int          cyc;
        int          first;
        int          second;
        bit          busy_seen;
        logic [15:0] addr;
        logic        sz;
        logic        wr;
        int          a;

        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        md_m = 16'h0000;
        mio_en = 1'b0; mar_addr = 16'h0; mar_size = 1'b0; mar_write = 1'b0; mdr_in = 16'h0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #11;
        check("rst_r", 32'(r), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_align", 32'(align_err), 32'd0);
        check("rst_mem_data", 32'(mem_data), 32'd0);
        #10 rst_n = 1'b1;

        // Word write/read and byte view
        run(16'h0010, 1'b1, 1'b1, 16'hBEEF);
        run(16'h0010, 1'b1, 1'b0, 16'h0000);
        check("word_rd_beef", 32'(last_rd), 32'h0000BEEF);
        run(16'h0011, 1'b0, 1'b0, 16'h0000);
        check("byte_rd_be", 32'(last_rd), 32'h000000BE);

        // Byte write keeps the neighbour
        run(16'h0011, 1'b0, 1'b1, 16'h1234);
        run(16'h0010, 1'b1, 1'b0, 16'h0000);
        check("byte_wr_34ef", 32'(last_rd), 32'h000034EF);

        // Unaligned word read and write leave RAM alone
        run(16'h0020, 1'b1, 1'b1, 16'h7788);
        run(16'h0021, 1'b1, 1'b0, 16'h0000);
        check("unaligned_md", 32'(last_rd), 32'h0);
        run(16'h0021, 1'b1, 1'b1, 16'hFFFF);
        run(16'h0021, 1'b0, 1'b0, 16'h0000);
        check("unaligned_keep", 32'(last_rd), 32'h00000077);

        // Inputs changed and mio_en dropped during WAIT
        @(negedge clk);
        mio_en = 1'b1; mar_addr = 16'h0040; mar_size = 1'b1; mar_write = 1'b1; mdr_in = 16'h1357;
        @(posedge clk);
        #1;
        mar_addr = 16'h0050; mdr_in = 16'hFFFF; mio_en = 1'b0;
        npulse = 0;
        repeat (12) begin
            @(negedge clk);
            if (r) npulse++;
        end
        check("mid_r_count", npulse, 1);
        mem_m[16'h40] = 8'h57; known[16'h40] = 1'b1;
        mem_m[16'h41] = 8'h13; known[16'h41] = 1'b1;
        run(16'h0040, 1'b1, 1'b0, 16'h0000);
        check("mid_orig_data", 32'(last_rd), 32'h00001357);

        // Reset pulse in WAIT cycle 2 aborts a write
        run(16'h0060, 1'b1, 1'b1, 16'h2468);
        run(16'h0060, 1'b1, 1'b0, 16'h0000);
        @(negedge clk);
        mio_en = 1'b1; mar_addr = 16'h0060; mar_size = 1'b1; mar_write = 1'b1; mdr_in = 16'hDEAD;
        @(posedge clk);
        #1 mio_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_r", 32'(r), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_align", 32'(align_err), 32'd0);
        check("arst_mem_data", 32'(mem_data), 32'd0);
        #2 rst_n = 1'b1;
        npulse = 0;
        busy_seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (r) npulse++;
            if (busy) busy_seen = 1'b1;
        end
        check("arst_no_r", npulse, 0);
        check("arst_idle", 32'(busy_seen), 32'd0);
        md_m = 16'h0000;
        run(16'h0060, 1'b1, 1'b0, 16'h0000);
        check("arst_no_write", 32'(last_rd), 32'h00002468);

        // Top-of-RAM word and aliasing
        run(16'h03FE, 1'b1, 1'b1, 16'hC0DE);
        run(16'h07FF, 1'b0, 1'b0, 16'h0000);
        check("top_byte_alias", 32'(last_rd), 32'h000000C0);
        run(16'hFBFE, 1'b1, 1'b0, 16'h0000);
        check("top_word_alias", 32'(last_rd), 32'h0000C0DE);

        // Back-to-back with mio_en held high, aliased write then read of 0
        @(negedge clk);
        mio_en = 1'b1; mar_addr = 16'h0400; mar_size = 1'b1; mar_write = 1'b1; mdr_in = 16'hA5A5;
        @(posedge clk);
        #1;
        cyc = 0; first = -1; second = -1; npulse = 0;
        while (cyc < 40 && npulse < 2) begin
            @(negedge clk);
            cyc++;
            if (r) begin
                npulse++;
                if (npulse == 1) begin
                    first = cyc;
                    mar_addr = 16'h0000; mar_write = 1'b0; mdr_in = 16'h0000;
                end else begin
                    second = cyc;
                end
            end
        end
        mio_en = 1'b0;
        check("b2b_pulses", npulse, 2);
        check("b2b_first_lat", first, LAT + 1);
        check("b2b_gap", second - first, LAT + 2);
        check("b2b_data", 32'(mem_data), 32'h0000A5A5);
        mem_m[0] = 8'hA5; known[0] = 1'b1;
        mem_m[1] = 8'hA5; known[1] = 1'b1;
        md_m = 16'hA5A5;
        @(negedge clk);

        // Randomized accesses in a small aliased window
        for (int i = 0; i < 40; i++) begin
            addr = 16'($urandom_range(0, 31)) | (16'($urandom_range(0, 63)) << ABITS);
            sz   = 1'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            a    = addr % DEPTH;
            if (!wr && !(sz && addr[0])) begin
                if (!known[a] || (sz && !known[a+1])) wr = 1'b1;
            end
            run(addr, sz, wr, 16'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/lc3b_mem_ctrl.md
Name: lc3b_mem_ctrl

Overview:
- Memory-side stage directly downstream of the memory address register.
- Consumes the latched address, size flag (byte/word) and write flag from the MAR, plus the MDR write data.
- Runs a multi-cycle access to an internal byte-addressed little-endian RAM.
- Returns read data and a one-cycle ready (R) pulse to the control FSM.

Parameters:
ADDR_BITS, 10, number of low address bits decoded; RAM holds 2^ADDR_BITS bytes; higher address bits are ignored (aliasing).
LATENCY, 4, WAIT-state cycles per access; legal range 1..255.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
mio_en  input  1  access request; sampled only in IDLE.
mar_addr  input  16  byte address from MAR.
mar_size  input  1  0 = byte access, 1 = word access.
mar_write  input  1  0 = read, 1 = write.
mdr_in  input  16  write data; byte writes use bits [7:0].
mem_data  output  16  read data; holds its value until the next completed read or error.
r  output  1  ready; high for exactly one cycle when an access completes.
busy  output  1  high from accept until r (WAIT and DONE states).
align_err  output  1  high with r when a word access was unaligned; low otherwise.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; r=0, busy=0, align_err=0, mem_data=16'h0000; counter=0.
  - RAM contents are not cleared by reset.
  - Reset during WAIT aborts the access; no RAM write occurs unless the write edge has already passed.
- States: IDLE, WAIT, DONE.
- IDLE, mio_en=1 at edge E0:
  - Capture addr/size/write/mdr_in into internal registers; busy=1.
  - If mar_size=1 and mar_addr[0]=1: go to DONE with an error.
  - Otherwise: go to WAIT with cnt=LATENCY-1.
- IDLE, mio_en=0: remain in IDLE; all outputs held, r=0.
- WAIT:
  - Upstream inputs are ignored; captured values are used.
  - Deasserting mio_en does not cancel the access.
  - If cnt!=0: decrement cnt.
  - If cnt==0: perform the access at this edge, then go to DONE.
- Access rules, with a = captured_addr[ADDR_BITS-1:0]:
  - Byte read: mem_data = {8'h00, ram[a]}.
  - Byte write: ram[a] = mdr[7:0]; the neighbouring byte is unchanged.
  - Word read: mem_data = {ram[a+1], ram[a]}.
  - Word write: ram[a] = mdr[7:0], ram[a+1] = mdr[15:8].
  - Writes leave mem_data unchanged.
- Error path:
  - No RAM change; mem_data = 16'h0000.
  - align_err=1 during the DONE cycle only.
- DONE: r=1 for one cycle; next state is IDLE unconditionally. busy drops together with r.
- Latency:
  - Normal access: r is high in cycle E0+LATENCY+1, i.e. LATENCY+1 cycles after accept.
  - Error access: r is high in cycle E0+1.
- Back-to-back: if mio_en is still high in the IDLE cycle after DONE, a new access is accepted. The upstream FSM drops mio_en on seeing r.
- Address aliasing: mar_addr[15:ADDR_BITS] is ignored. Word access at the top-of-RAM aligned address 2^ADDR_BITS-2 is legal; a+1 never wraps because a is even.
- All outputs are registered; no combinational path exists from inputs to outputs.

Test Plan:
- Word write then read:
  - Stimulus: write addr 0x0010, word, data 0xBEEF, then read the same address as a word.
  - Required: r at cycle 5 after accept (LATENCY=4); mem_data=0xBEEF; byte read of 0x0011 returns 0x00BE.
- Byte write preserves neighbour:
  - Stimulus: after the word write above, byte write 0x0011 with data 0x1234, then word read 0x0010.
  - Required: mem_data=0x34EF.
- Unaligned word:
  - Stimulus: word read at 0x0021.
  - Required: r and align_err high in cycle 1 after accept; mem_data=0x0000; a subsequent byte read of 0x0021 shows unchanged contents.
- Mid-access behaviour:
  - Stimulus: start a write to 0x0040, change mar_addr and mdr_in and drop mio_en during WAIT.
  - Required: write lands at 0x0040 with the original data; exactly one r pulse.
  - Stimulus: separately, pulse rst_n low in WAIT cycle 2.
  - Required: outputs zero immediately, state IDLE, no r, target bytes unchanged.
- Aliasing and back-to-back:
  - Stimulus: word write 0x0400 data 0xA5A5 (ADDR_BITS=10), hold mio_en high, and switch to a read of 0x0000.
  - Required: the second access is accepted in the IDLE cycle after r; it returns 0xA5A5 with two distinct r pulses.
